// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: size encodings and FSM state type shared by the load/store unit
package mem_lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;
endpackage

// File: rtl/mem_lsu_lane.sv
// mem_lsu_lane: little-endian lane extract/extend for loads and lane merge for stores (word_i, wd_i, off_i, size_i, sign_i -> ld_o, st_o)
module mem_lsu_lane
  import mem_lsu_pkg::*;
#(
  parameter int S = 32
) (
  input  logic [S-1:0] word_i,
  input  logic [15:0]  wd_i,
  input  logic [1:0]   off_i,
  input  logic [1:0]   size_i,
  input  logic         sign_i,
  output logic [S-1:0] ld_o,
  output logic [S-1:0] st_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word_i[{off_i, 3'b000} +: 8];
  assign h = word_i[{off_i[1], 4'b0000} +: 16];
  assign ld_o = size_i[1] ? word_i :
                size_i[0] ? {{(S-16){sign_i & h[15]}}, h} : {{(S-8){sign_i & b[7]}}, b};
  always_comb begin
    st_o = word_i;
    if (size_i == SZ_BYTE) st_o[{off_i, 3'b000} +: 8] = wd_i[7:0];
    else if (size_i == SZ_HALF) st_o[{off_i[1], 4'b0000} +: 16] = wd_i;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: req/busy/done load/store unit with sub-word RMW stores; ports clk, rst, req, we, size, sign, addr, wdata -> rdata, busy, done, err; memory side a, din, mread, mwrite, dout; LSU_ERR_CHECK_EN enables misalignment errors
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int S = 32,
  parameter int L = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic                 sign,
  input  logic [$clog2(L)+1:0] addr,
  input  logic [S-1:0]         wdata,
  output logic [S-1:0]         rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [$clog2(L)-1:0] a,
  output logic [S-1:0]         din,
  output logic                 mread,
  output logic                 mwrite,
  input  logic [S-1:0]         dout
);
  localparam int AW = $clog2(L);
  state_t          state_q, state_d;
  logic [AW-1:0]   a_q;
  logic [S-1:0]    din_q, rdata_q, ld, st;
  logic [15:0]     wdata_q;
  logic [1:0]      off_q, size_q;
  logic            sign_q, mis, acc;
  assign acc = (state_q == IDLE) && req;
`ifdef LSU_ERR_CHECK_EN
  logic err_q;
  assign mis = ((size == SZ_HALF) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else if (acc) err_q <= mis;
  assign err = err_q && done;
`else
  assign mis = 1'b0;
  assign err = 1'b0;
`endif
  mem_lsu_lane #(.S(S)) u_lane (
    .word_i(dout), .wd_i(wdata_q), .off_i(off_q), .size_i(size_q), .sign_i(sign_q),
    .ld_o(ld), .st_o(st)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = mis ? DONE : !we ? LOAD : size[1] ? WRITE : RMW_RD;
      LOAD:    state_d = DONE;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q     <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      if (acc) begin
        a_q     <= addr[AW+1:2];
        off_q   <= addr[1:0];
        size_q  <= size;
        sign_q  <= sign;
        wdata_q <= wdata[15:0];
        if (we && size[1] && !mis) din_q <= wdata;
      end
      if (state_q == RMW_RD) din_q <= st;
      if (state_q == LOAD) rdata_q <= ld;
    end
  assign a      = a_q;
  assign din    = din_q;
  assign rdata  = rdata_q;
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
  assign mread  = (state_q == LOAD) || (state_q == RMW_RD);
  assign mwrite = state_q == WRITE;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table-driven self-checking bench for mem_lsu with a behavioural word memory
module tb_mem_lsu;
  logic        clk = 0, rst = 1, req = 0, we = 0, sign = 0;
  logic [1:0]  size = 0;
  logic [9:0]  addr = 0;
  logic [31:0] wdata = 0, rdata, din, dout;
  logic [7:0]  a;
  logic        busy, done, err, mread, mwrite;
  logic [31:0] mem [256];
  int          nwr = 0;
  int          checks = 0, errors = 0;

  mem_lsu dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign(sign), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err), .a(a), .din(din),
    .mread(mread), .mwrite(mwrite), .dout(dout)
  );

  always #5 clk = ~clk;
  assign dout = mem[a];
  always @(posedge clk) if (mwrite) begin mem[a] <= din; nwr++; end

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [9:0]  ad;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    int          nr;
    int          nw;
    logic        e;
  } vec_t;
  vec_t v[15];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic do_op(input logic w, input logic [1:0] sz, input logic sg, input logic [9:0] ad,
                       input logic [31:0] wd, output int lat, output int nr, output int nw,
                       output logic e, output logic both);
    @(negedge clk);
    req = 1; we = w; size = sz; sign = sg; addr = ad; wdata = wd;
    @(posedge clk);
    #1 req = 0;
    lat = -1; nr = 0; nw = 0; e = 0; both = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      nr += int'(mread);
      nw += int'(mwrite);
      if (mread && mwrite) both = 1;
      if (done) begin lat = c; e = err; break; end
    end
  endtask

  initial begin
    int lat, nr, nw, w0;
    logic e, both;
    logic [31:0] last;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[3] = 32'h8899AABB;
    v[0]  = '{0, 2'b10, 0, 10'h0C, 32'h0,        32'h8899AABB, 2, 1, 0, 0};
    v[1]  = '{0, 2'b00, 1, 10'h0F, 32'h0,        32'hFFFFFF88, 2, 1, 0, 0};
    v[2]  = '{0, 2'b01, 0, 10'h0C, 32'h0,        32'h0000AABB, 2, 1, 0, 0};
    v[3]  = '{0, 2'b00, 0, 10'h0E, 32'h0,        32'h00000099, 2, 1, 0, 0};
    v[4]  = '{0, 2'b01, 1, 10'h0E, 32'h0,        32'hFFFF8899, 2, 1, 0, 0};
    v[5]  = '{1, 2'b00, 0, 10'h0D, 32'hFFFFFF55, 32'h0,        3, 1, 1, 0};
    v[6]  = '{0, 2'b10, 0, 10'h0C, 32'h0,        32'h889955BB, 2, 1, 0, 0};
    v[7]  = '{1, 2'b01, 0, 10'h0E, 32'hABCD1234, 32'h0,        3, 1, 1, 0};
    v[8]  = '{0, 2'b10, 0, 10'h0C, 32'h0,        32'h123455BB, 2, 1, 0, 0};
    v[9]  = '{1, 2'b10, 0, 10'h10, 32'hDEADBEEF, 32'h0,        2, 0, 1, 0};
    v[10] = '{0, 2'b11, 0, 10'h10, 32'h0,        32'hDEADBEEF, 2, 1, 0, 0};
`ifdef LSU_ERR_CHECK_EN
    v[11] = '{0, 2'b10, 0, 10'h0E, 32'h0,        32'h0,        1, 0, 0, 1};
    v[12] = '{0, 2'b01, 0, 10'h0D, 32'h0,        32'h0,        1, 0, 0, 1};
`else
    v[11] = '{0, 2'b10, 0, 10'h0E, 32'h0,        32'h123455BB, 2, 1, 0, 0};
    v[12] = '{0, 2'b01, 0, 10'h0D, 32'h0,        32'h000055BB, 2, 1, 0, 0};
`endif
    v[13] = '{1, 2'b00, 0, 10'h13, 32'h000000A5, 32'h0,        3, 1, 1, 0};
    v[14] = '{0, 2'b10, 0, 10'h10, 32'h0,        32'hA5ADBEEF, 2, 1, 0, 0};

    #12;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_mrw", {30'b0, mread, mwrite}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_din_a", {din[23:0], a}, 0);
    @(negedge clk) rst = 0;

    last = 32'h0;
    for (int i = 0; i < 15; i++) begin
      w0 = nwr;
      do_op(v[i].w, v[i].sz, v[i].sg, v[i].ad, v[i].wd, lat, nr, nw, e, both);
      if (!v[i].w && !v[i].e) last = v[i].rd;
      chk($sformatf("v%0d_lat", i), lat, v[i].lat);
      chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, v[i].e});
      chk($sformatf("v%0d_rdata", i), rdata, last);
      chk($sformatf("v%0d_mread", i), nr, v[i].nr);
      chk($sformatf("v%0d_mwrite", i), nw, v[i].nw);
      chk($sformatf("v%0d_excl", i), {31'b0, both}, 0);
      #6 chk($sformatf("v%0d_wrcnt", i), nwr - w0, v[i].nw);
    end
    chk("mem3_final", mem[3], 32'h123455BB);

    w0 = nwr;
    @(negedge clk);
    req = 1; we = 1; size = 2'b10; addr = 10'h14; wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 addr = 10'h18; wdata = 32'h11111111;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) begin lat = c; req = 0; break; end
    end
    req = 0;
    repeat (3) @(negedge clk);
    chk("busy_lat", lat, 2);
    chk("busy_wrcnt", nwr - w0, 1);
    chk("busy_mem5", mem[5], 32'hCAFEF00D);
    chk("busy_mem6", mem[6], 32'h0);

    @(negedge clk);
    req = 1; we = 1; size = 2'b01; addr = 10'h0C; wdata = 32'h0000FFFF;
    @(posedge clk);
    #1 req = 0;
    @(negedge clk);
    chk("rmw_mread", {31'b0, mread}, 1);
    rst = 1;
    #1;
    chk("mid_busy", {31'b0, busy}, 0);
    chk("mid_flags", {29'b0, done, err, mread | mwrite}, 0);
    chk("mid_a", {24'b0, a}, 0);
    chk("mid_din", din, 0);
    chk("mid_rdata", rdata, 0);
    repeat (3) @(negedge clk);
    chk("mid_mem3", mem[3], 32'h123455BB);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("post_busy", {31'b0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit that drives the synchronous data memory from the CPU side of the single-cycle MIPS datapath. It accepts byte, halfword and word requests with a req/busy/done handshake and generates the word address, `mread`, `mwrite` and `din` signals. Sub-word loads are extracted and sign- or zero-extended from `dout`. Sub-word stores use a read-modify-write sequence, because the data memory writes whole words only.

## Interface
- `S`, 32: data word width.
- `L`, 256: memory length in words; word address width is `$clog2(L)`, byte address width is `$clog2(L)+2`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  request strobe; sampled only while `busy`=0.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- `sign`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `addr`  in  `$clog2(L)+2`  byte address.
- `wdata`  in  S  store data; bytes are taken from the low end.
- `rdata`  out  S  load result; held until the next load completes.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  misalignment flag; valid with `done`.
- `a`  out  `$clog2(L)`  word address to memory, `addr[$clog2(L)+1:2]`.
- `din`  out  S  write data to memory.
- `mread`  out  1  memory read enable.
- `mwrite`  out  1  memory write enable.
- `dout`  in  S  memory read data; combinational from `a`.

## Operation
- FSM states:
  - IDLE: `busy`=0; waits for `req`.
  - LOAD: `mread`=1; latches the extracted value into `rdata` at the end of the cycle.
  - RMW_RD: `mread`=1; latches `dout` into the merge buffer.
  - WRITE: `mwrite`=1; `din` holds the full or merged word.
  - DONE: `done`=1 for one cycle, then returns to IDLE.
- Transitions out of IDLE on `req`:
  - Load → LOAD.
  - Word store → WRITE.
  - Byte or halfword store → RMW_RD, then WRITE.
  - Misaligned request with `LSU_ERR_CHECK_EN` defined → DONE with `err`=1.
- Byte lanes are little-endian:
  - A byte at `addr[1:0]`=k occupies `dout[8k+7:8k]`.
  - A halfword at `addr[1]`=h occupies `dout[16h+15:16h]`.
- Store merge replaces only the addressed lane(s) of the buffered word with `wdata[7:0]` or `wdata[15:0]`. All other bits are preserved.
- `a`, `we`, `size`, `sign`, `addr` and `wdata` are captured at acceptance. Later changes to the inputs do not affect an in-flight access.
- A `req` that arrives while `busy`=1 is ignored. It is not queued.
- `mread` and `mwrite` are never high in the same cycle.

## Timing
- Reset values: IDLE state; `rdata`, `din`, `a` all 0; `busy`, `done`, `err`, `mread`, `mwrite` all 0.
- Latency counts the acceptance edge as cycle 0; `done` is high in the listed cycle.
  - Load: cycle 2.
  - Word store: cycle 2.
  - Sub-word store: cycle 3.
  - Misaligned request: cycle 1.
- Back-to-back requests: the earliest next acceptance is the cycle after `done`, because `busy` drops with the return to IDLE.
- `rdata` updates on the edge that enters DONE and is stable while `done`=1.
- Reset asserted mid-operation:
  - Outputs clear immediately and the FSM returns to IDLE.
  - If reset lands before the WRITE edge, the memory is unchanged.
  - A sub-word RMW is never partially written.

## Configuration
- `LSU_ERR_CHECK_EN` defined:
  - A halfword with `addr[0]`=1 or a word with `addr[1:0]`≠0 raises `err`.
  - No memory access is made, and `rdata` is unchanged.
- `LSU_ERR_CHECK_EN` undefined:
  - `err` is tied to 0.
  - Unaligned low bits are ignored: a halfword uses `addr[1]`, a word ignores `addr[1:0]`.

## Structure
- Package `mem_lsu_pkg`:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - FSM state enum.
- Sub-module `mem_lsu_lane`, combinational:
  - Load path: lane extraction plus sign/zero extension.
  - Store path: lane merge.
  - Instantiated once.

## Test plan
- Preload word 3 = 0x8899AABB. Load word at addr 0x0C → `done` in cycle 2, `rdata`=0x8899AABB, `mread` high for exactly one cycle.
- Same memory contents:
  - Signed byte load at 0x0F → `rdata`=0xFFFFFF88.
  - Unsigned halfword load at 0x0C → `rdata`=0x0000AABB.
- Byte store 0x55 to 0x0D → sequence RMW_RD, WRITE, `done` in cycle 3. Word 3 then reads 0x889955BB.
- Word store 0xDEADBEEF to 0x10, then an immediate next `req` while `busy` → only one write occurs. Word 4 = 0xDEADBEEF.
- With `LSU_ERR_CHECK_EN`:
  - Word load at 0x0E → `done`+`err` in cycle 1, no `mread`.
  - Without the macro, the same request returns word 3.
- Assert `rst` in the RMW_RD cycle of a halfword store → all outputs 0 immediately and word 3 is unchanged.
